// File: rtl/mux4x1_arb_pkg.sv
// Shared types and helpers for the mux4x1 round-robin arbiter.
// State encoding is fixed so that GRANT doubles as the registered valid flag.
package mux4x1_arb_pkg;

   localparam int NREQ = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   function automatic logic [NREQ-1:0] idx2onehot(input logic [1:0] idx);
      idx2onehot = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux4x1_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request bit searching
// start, start+1, start+2, start+3 (mod 4).
module rr_pick4
   import mux4x1_arb_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] start,
   output logic       found,
   output logic [1:0] idx
);

   logic [1:0] cand;

   // Walk the offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      found = 1'b0;
      idx   = start;
      cand  = start;
      for (int off = NREQ - 1; off >= 0; off--) begin
         cand = start + 2'(off);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin arbiter sharing one mux4x1 datapath among four requesters.
// Define MUX4X1_ARB_LOCK_EN to add a lock input that pins the current owner.
module mux4x1_rr_arbiter
   import mux4x1_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef MUX4X1_ARB_LOCK_EN
   input  logic       lock,
`endif
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       s1,
   output logic       s0,
   output logic       valid
);

   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

   arb_state_e       state_q, state_nxt;
   logic [1:0]       owner_q, owner_nxt;
   logic [1:0]       ptr_q, ptr_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [3:0]       gnt_q, gnt_nxt;
   logic [1:0]       owner_inc, pick_start, pick_idx;
   logic             pick_found, others_req, lock_hold;

`ifdef MUX4X1_ARB_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   // In GRANT the owner is searched last, so a hit is always someone else first.
   assign owner_inc  = owner_q + 2'd1;
   assign pick_start = (state_q == GRANT) ? owner_inc : ptr_q;
   assign others_req = |(req & ~idx2onehot(owner_q));

   rr_pick4 u_pick (
      .req   (req),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         owner_q <= owner_nxt;
         ptr_q   <= ptr_nxt;
         cnt_q   <= cnt_nxt;
         gnt_q   <= gnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      owner_nxt = owner_q;
      ptr_nxt   = ptr_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_nxt = GRANT;
               owner_nxt = pick_idx;
               cnt_nxt   = HOLD_ONE;
            end
         end
         GRANT: begin
            if (!req[owner_q]) begin
               ptr_nxt = owner_inc;
               if (pick_found) begin
                  owner_nxt = pick_idx;
                  cnt_nxt   = HOLD_ONE;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (lock_hold) begin
               if (cnt_q < HOLD_MAX) cnt_nxt = cnt_q + HOLD_ONE;
            end else if (cnt_q < HOLD_MAX) begin
               cnt_nxt = cnt_q + HOLD_ONE;
            end else if (others_req) begin
               owner_nxt = pick_idx;
               ptr_nxt   = owner_inc;
               cnt_nxt   = HOLD_ONE;
            end else begin
               // Sole requester at the limit keeps the bus; tenure restarts.
               cnt_nxt = HOLD_ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      gnt_nxt = (state_nxt == GRANT) ? idx2onehot(owner_nxt) : 4'b0000;
   end

   always_comb begin
      gnt   = gnt_q;
      valid = (state_q == GRANT);
      s1    = owner_q[1];
      s0    = owner_q[0];
   end

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Self-checking bench for mux4x1_rr_arbiter: directed scenarios plus
// randomized traffic against a behavioural round-robin model.
module tb_mux4x1_rr_arbiter;

   localparam int MH       = 4;
   localparam int WAIT_MAX = 3 * MH + 1;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic       lock  = 1'b0;
   logic [3:0] gnt;
   logic       s1, s0, valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state: owner -1 means nobody holds the mux.
   int m_owner = -1;
   int m_sel   = 0;
   int m_ptr   = 0;
   int m_cnt   = 0;

   logic [7:0] din [4];

   always #5 clk = ~clk;

   mux4x1_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef MUX4X1_ARB_LOCK_EN
      .lock  (lock),
`endif
      .req   (req),
      .gnt   (gnt),
      .s1    (s1),
      .s0    (s0),
      .valid (valid)
   );

   function automatic int find_next(int start, logic [3:0] r);
      for (int j = 0; j < 4; j++)
         if (r[(start + j) % 4]) return (start + j) % 4;
      return -1;
   endfunction

   task automatic model_step();
      int k;
      if (!rst_n) begin
         m_owner = -1; m_sel = 0; m_ptr = 0; m_cnt = 0;
      end else if (m_owner < 0) begin
         k = find_next(m_ptr, req);
         if (k >= 0) begin m_owner = k; m_sel = k; m_cnt = 1; end
      end else if (!req[m_owner]) begin
         m_ptr = (m_owner + 1) % 4;
         k = find_next(m_ptr, req);
         if (k >= 0) begin m_owner = k; m_sel = k; m_cnt = 1; end
         else m_owner = -1;
      end else if (lock) begin
         if (m_cnt < MH) m_cnt++;
      end else if (m_cnt < MH) begin
         m_cnt++;
      end else if ((req & ~(4'b0001 << m_owner)) != 4'b0000) begin
         m_ptr = (m_owner + 1) % 4;
         k = find_next(m_ptr, req);
         m_owner = k; m_sel = k; m_cnt = 1;
      end else begin
         m_cnt = 1;
      end
   endtask

   function automatic logic [6:0] model_out();
      logic [3:0] g;
      logic [1:0] s;
      g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      s = m_sel[1:0];
      return {g, s, (m_owner >= 0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 4'b1111;
      tick(); tick();
      n_tests++;
      if ({gnt, s1, s0, valid} !== 7'b0000_00_0) begin
         n_fail++;
         $display("FAIL reset_state: got gnt=%b sel=%b%b valid=%b, need gnt=0000 sel=00 valid=0", gnt, s1, s0, valid);
      end
      rst_n = 1'b1;
      tick(); tick();
      n_tests++;
      if (gnt !== 4'b0001 || valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_grant: got gnt=%b valid=%b, need gnt=0001 valid=1", gnt, valid);
      end
      rst_n = 1'b0;
      tick();
      n_tests++;
      if (gnt !== 4'b0000 || valid !== 1'b0 || {s1, s0} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_mid_grant: got gnt=%b sel=%b%b valid=%b, need 0000/00/0", gnt, s1, s0, valid);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_owner();
      rst_n = 1'b0; req = 4'b0000; tick();
      rst_n = 1'b1; req = 4'b0100;
      tick();
      n_tests++;
      if ({gnt, s1, s0, valid} !== 7'b0100_10_1) begin
         n_fail++;
         $display("FAIL single_latency: got gnt=%b sel=%b%b valid=%b, need 0100/10/1", gnt, s1, s0, valid);
      end
      for (int c = 0; c < 22; c++) begin
         for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
         tick();
         n_tests++;
         if (gnt !== 4'b0100 || din[{s1, s0}] !== din[2]) begin
            n_fail++;
            $display("FAIL single_hold c=%0d: got gnt=%b y=%h, need gnt=0100 y=%h", c, gnt, din[{s1, s0}], din[2]);
         end
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_g;
      logic [1:0] exp_s;
      rst_n = 1'b0; req = 4'b0000; tick();
      rst_n = 1'b1; req = 4'b1111;
      for (int c = 0; c < 24; c++) begin
         tick();
         exp_s = 2'((c / MH) % 4);
         exp_g = 4'b0001 << exp_s;
         n_tests++;
         if (gnt !== exp_g || {s1, s0} !== exp_s || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rotation c=%0d: got gnt=%b sel=%b%b valid=%b, need gnt=%b sel=%b valid=1", c, gnt, s1, s0, valid, exp_g, exp_s);
         end
      end
   endtask

   task automatic test_back_to_back();
      rst_n = 1'b0; req = 4'b0000; tick();
      rst_n = 1'b1; req = 4'b0010; tick();
      req = 4'b0011; tick();
      n_tests++;
      if (gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL b2b_owner1: got gnt=%b, need 0010", gnt);
      end
      req = 4'b1001; tick();
      n_tests++;
      if ({gnt, s1, s0, valid} !== 7'b1000_11_1) begin
         n_fail++;
         $display("FAIL b2b_handoff: got gnt=%b sel=%b%b valid=%b, need 1000/11/1", gnt, s1, s0, valid);
      end
   endtask

   task automatic test_release_idle();
      req = 4'b0000; tick();
      n_tests++;
      if ({gnt, s1, s0, valid} !== 7'b0000_11_0) begin
         n_fail++;
         $display("FAIL release_idle: got gnt=%b sel=%b%b valid=%b, need 0000/11/0", gnt, s1, s0, valid);
      end
      req = 4'b1111; tick();
      n_tests++;
      if ({gnt, s1, s0, valid} !== 7'b0001_00_1) begin
         n_fail++;
         $display("FAIL ptr_wrap: got gnt=%b sel=%b%b valid=%b, need 0001/00/1", gnt, s1, s0, valid);
      end
   endtask

`ifdef MUX4X1_ARB_LOCK_EN
   task automatic test_lock();
      rst_n = 1'b0; req = 4'b0000; lock = 1'b0; tick();
      rst_n = 1'b1; req = 4'b0001; tick();
      req = 4'b1111; lock = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_tests++;
         if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL lock_hold c=%0d: got gnt=%b, need 0001", c, gnt);
         end
      end
      lock = 1'b0; tick();
      n_tests++;
      if (gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL lock_drop: got gnt=%b, need 0010", gnt);
      end
   endtask
`endif

   task automatic test_random();
      int wait_cnt [4];
      int worst;
      logic [6:0] exp_o;
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      rst_n = 1'b0; req = 4'b0000; lock = 1'b0; tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
`ifdef MUX4X1_ARB_LOCK_EN
         if ($urandom_range(0, 15) == 0) lock = ~lock;
`endif
         tick();
         exp_o = model_out();
         n_tests++;
         if ({gnt, s1, s0, valid} !== exp_o) begin
            n_fail++;
            $display("FAIL random c=%0d req=%b: got gnt=%b sel=%b%b valid=%b, need gnt=%b sel=%b valid=%b",
                     c, req, gnt, s1, s0, valid, exp_o[6:3], exp_o[2:1], exp_o[0]);
         end
         worst = 0;
         for (int i = 0; i < 4; i++) begin
            if (!rst_n || !req[i] || gnt[i]) wait_cnt[i] = 0;
            else wait_cnt[i]++;
            if (wait_cnt[i] > worst) worst = wait_cnt[i];
         end
`ifndef MUX4X1_ARB_LOCK_EN
         n_tests++;
         if (worst > WAIT_MAX) begin
            n_fail++;
            $display("FAIL wait_bound c=%0d: got wait=%0d, need <= %0d", c, worst, WAIT_MAX);
         end
`endif
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) din[i] = 8'h00;
      test_reset();
      test_single_owner();
      test_rotation();
      test_back_to_back();
      test_release_idle();
`ifdef MUX4X1_ARB_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
